// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline stall/flush sequencer with a data-memory wait-state FSM
module pipe_hazard_ctrl #(
  parameter int MAX_WAIT = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             idex_memread_i,
  input  logic [4:0]       idex_rd_i,
  input  logic [4:0]       ifid_rs_i,
  input  logic [4:0]       ifid_rt_i,
  input  logic             branch_taken_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ack_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_write_o,
  output logic             idex_bubble_o,
  output logic             exmem_write_o,
  output logic             memwb_bubble_o,
  output logic             err_o,
  output logic [CNT_W-1:0] stall_cnt_o
);
  localparam int WW = $clog2(MAX_WAIT + 1) + 1;
  typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;
  state_t state, state_nx;
  logic [WW-1:0] wait_cnt, wait_nx;
  logic [CNT_W-1:0] stall_cnt;
  logic lu, mw, freeze, go;
  assign lu = idex_memread_i & (idex_rd_i != 5'd0) & ((idex_rd_i == ifid_rs_i) | (idex_rd_i == ifid_rt_i));
  assign mw = dmem_req_i & ~dmem_ack_i;
  // wait_cnt counts frozen cycles of the current access; reaching MAX_WAIT is fatal
  always_comb begin
    state_nx = state;
    wait_nx = wait_cnt;
    freeze = 1'b0;
    case (state)
      RUN: if (mw) begin
        freeze = 1'b1;
        wait_nx = WW'(1);
        state_nx = (MAX_WAIT == 1) ? ERR : MEM_WAIT;
      end
      MEM_WAIT: if (dmem_ack_i) begin
        state_nx = RUN;
        wait_nx = '0;
      end else begin
        freeze = 1'b1;
        wait_nx = wait_cnt + 1'b1;
        state_nx = (wait_cnt == WW'(MAX_WAIT - 1)) ? ERR : MEM_WAIT;
      end
      default: freeze = 1'b1;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= RUN;
      wait_cnt <= '0;
    end else begin
      state <= state_nx;
      wait_cnt <= wait_nx;
    end
  end
  // outputs are gated by rst_i so reset forces them low without a clock edge
  assign go = rst_i & ~freeze;
  assign pc_write_o = go & ~lu;
  assign ifid_write_o = go & ~lu;
  assign ifid_flush_o = go & ~lu & branch_taken_i;
  assign idex_write_o = go;
  assign idex_bubble_o = go & lu;
  assign exmem_write_o = go;
  assign memwb_bubble_o = rst_i & freeze;
  assign err_o = rst_i & (state == ERR);
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) stall_cnt <= '0;
    else if (!pc_write_o && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
  end
  assign stall_cnt_o = stall_cnt;
endmodule
